// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//   I2C target (slave) front end that exposes a byte-addressed register
//   space. The first data byte of a write sets the register pointer and
//   each later byte is presented as a write strobe. A read streams bytes
//   starting at the pointer. The pointer auto-increments and is kept across
//   STOP and repeated START.
//
// Ports
//   i_clk          system clock (>= 16x SCL)
//   i_rstN         asynchronous active-low reset
//   i_scl, i_sda   raw bus pin levels, asynchronous to i_clk
//   o_sdaDriveLow  1 = pull SDA low (open-drain pad)
//   o_regAddress   register pointer
//   o_wrData       last data byte received
//   o_wrStrobe     1-cycle pulse: write o_wrData to o_regAddress
//   i_rdData       register contents at o_regAddress
//   o_rdStrobe     1-cycle pulse: i_rdData captured for transmission
//   o_busy         high from START to STOP
// ---------------------------------------------------------------------------
module i2c_target_regs #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h48
) (
   input  logic       i_clk,
   input  logic       i_rstN,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sdaDriveLow,
   output logic [7:0] o_regAddress,
   output logic [7:0] o_wrData,
   output logic       o_wrStrobe,
   input  logic [7:0] i_rdData,
   output logic       o_rdStrobe,
   output logic       o_busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  scl_sync_q, sda_sync_q;   // [0],[1] synchroniser, [2] history
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  rx_q, rx_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        drv_q, drv_d;
   logic        wr_stb_q, wr_stb_d;
   logic        rd_stb_q, rd_stb_d;
   logic        busy_q, busy_d;
   logic        load_tx;

   // Reset to 1 (idle bus) so reset release cannot look like START/STOP.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], i_scl};
         sda_sync_q <= {sda_sync_q[1:0], i_sda};
      end
   end

   logic scl, scl_h, sda, sda_h;
   assign scl   = scl_sync_q[1];
   assign scl_h = scl_sync_q[2];
   assign sda   = sda_sync_q[1];
   assign sda_h = sda_sync_q[2];

   logic scl_rise, scl_fall, start, stop, addr_match;
   assign scl_rise   = scl & ~scl_h;
   assign scl_fall   = ~scl & scl_h;
   assign start      = scl & scl_h & sda_h & ~sda;
   assign stop       = scl & scl_h & ~sda_h & sda;
   assign addr_match = (rx_q[7:1] == SLAVE_ADDRESS);

   // State and datapath registers
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rx_q     <= '0;
         tx_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         drv_q    <= 1'b0;
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         drv_q    <= drv_d;
         wr_stb_q <= wr_stb_d;
         rd_stb_q <= rd_stb_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state logic. Byte/ACK boundaries advance on the SCL fall that
   // ends the current clock, so SDA only ever changes while SCL is low.
   always_comb begin
      state_d = state_q;
      if (stop)       state_d = IDLE;
      else if (start) state_d = ADDR;
      else begin
         case (state_q)
            ADDR:      if (scl_fall && cnt_q == 4'd8) state_d = addr_match ? ADDR_ACK : IGNORE;
            ADDR_ACK:  if (scl_fall) state_d = rx_q[0] ? READ : REG;
            REG:       if (scl_fall && cnt_q == 4'd8) state_d = REG_ACK;
            REG_ACK:   if (scl_fall) state_d = WRITE;
            WRITE:     if (scl_fall && cnt_q == 4'd8) state_d = WRITE_ACK;
            WRITE_ACK: if (scl_fall) state_d = WRITE;
            READ:      if (scl_fall && cnt_q == 4'd8) state_d = READ_ACK;
            READ_ACK:  if (scl_fall) state_d = rx_q[0] ? IGNORE : READ;
            default:   state_d = state_q;
         endcase
      end
   end

   // Datapath / output-register next values
   always_comb begin
      cnt_d    = cnt_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      drv_d    = drv_q;
      wdata_d  = wdata_q;
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      busy_d   = busy_q;
      load_tx  = 1'b0;
      // pointer steps the cycle after a write strobe
      addr_d   = wr_stb_q ? addr_q + 8'd1 : addr_q;
      if (stop) begin
         busy_d = 1'b0;
         drv_d  = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         busy_d = 1'b1;
         drv_d  = 1'b0;
         cnt_d  = '0;
      end else begin
         case (state_q)
            ADDR, REG, WRITE: begin
               if (scl_rise && cnt_q != 4'd8) begin
                  rx_d  = {rx_q[6:0], sda};
                  cnt_d = cnt_q + 4'd1;
                  if (state_q == WRITE && cnt_q == 4'd7) begin
                     wdata_d  = {rx_q[6:0], sda};
                     wr_stb_d = 1'b1;
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  cnt_d = '0;
                  drv_d = (state_q != ADDR) || addr_match;   // ACK
                  if (state_q == REG) addr_d = rx_q;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               drv_d   = 1'b0;
               cnt_d   = '0;
               load_tx = rx_q[0];
            end
            REG_ACK, WRITE_ACK: if (scl_fall) begin
               drv_d = 1'b0;
               cnt_d = '0;
            end
            READ: if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  drv_d = 1'b0;             // release for master's ACK
                  cnt_d = '0;
               end else begin
                  drv_d = ~tx_q[7];
                  tx_d  = {tx_q[6:0], 1'b0};
                  cnt_d = cnt_q + 4'd1;
               end
            end
            READ_ACK: begin
               if (scl_rise) rx_d = {rx_q[6:0], sda};
               else if (scl_fall) begin
                  drv_d   = 1'b0;
                  load_tx = ~rx_q[0];
               end
            end
            default: drv_d = 1'b0;
         endcase
         // Capture next read byte; MSB goes on the bus now, the rest shift
         // out on following falls (cnt counts bits already presented).
         if (load_tx) begin
            tx_d     = {i_rdData[6:0], 1'b0};
            drv_d    = ~i_rdData[7];
            cnt_d    = 4'd1;
            rd_stb_d = 1'b1;
            addr_d   = addr_q + 8'd1;
         end
      end
   end

   // Outputs
   always_comb begin
      o_sdaDriveLow = drv_q;
      o_regAddress  = addr_q;
      o_wrData      = wdata_q;
      o_wrStrobe    = wr_stb_q;
      o_rdStrobe    = rd_stb_q;
      o_busy        = busy_q;
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//   Directed bench: a bit-banged I2C master (16 clocks per SCL period) on an
//   open-drain wired SDA, a register-file model answering i_rdData, and a
//   monitor logging strobes and cycles where the target pulls SDA low.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

   logic       clk;
   logic       rst_n;
   logic       scl;
   logic       m_sda;
   logic       drv;
   logic [7:0] reg_addr, wr_data, rd_data;
   logic       wr_stb, rd_stb, busy;
   logic       sda_bus;
   logic [7:0] mem [256];

   int n_checks = 0;
   int n_errors = 0;
   int n_rd  = 0;
   int n_drv = 0;
   logic [7:0] wq_a[$];
   logic [7:0] wq_d[$];

   assign sda_bus = m_sda & ~drv;
   assign rd_data = mem[reg_addr];

   i2c_target_regs #(.SLAVE_ADDRESS(7'h48)) dut (
      .i_clk(clk), .i_rstN(rst_n), .i_scl(scl), .i_sda(sda_bus),
      .o_sdaDriveLow(drv), .o_regAddress(reg_addr), .o_wrData(wr_data),
      .o_wrStrobe(wr_stb), .i_rdData(rd_data), .o_rdStrobe(rd_stb), .o_busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_stb) begin
         wq_a.push_back(reg_addr);
         wq_d.push_back(wr_data);
      end
      if (rd_stb) n_rd++;
      if (drv) n_drv++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL clock; SDA set mid-low, bus sampled mid-high.
   task automatic clk_bit(input logic b, output logic s);
      tick(5); m_sda = b;
      tick(5); scl = 1'b1;
      tick(6); s = sda_bus;
      scl = 1'b0;
   endtask

   task automatic i2c_start;
      tick(5); m_sda = 1'b1;
      tick(5); scl = 1'b1;
      tick(5); m_sda = 1'b0;
      tick(5); scl = 1'b0;
   endtask

   task automatic i2c_stop;
      tick(5); m_sda = 1'b0;
      tick(5); scl = 1'b1;
      tick(5); m_sda = 1'b1;
      tick(5);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(nack, s);
   endtask

   initial begin
      logic       a0, a1, a2, a3, s;
      logic [7:0] d0, d1;
      int         qb, rb, db;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h3C;
      mem[8'h11] = 8'hC3;
      rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
      tick(3);
      check("rst_drv",   drv, 0);
      check("rst_addr",  reg_addr, 0);
      check("rst_wdata", wr_data, 0);
      check("rst_wstb",  wr_stb, 0);
      check("rst_rstb",  rd_stb, 0);
      check("rst_busy",  busy, 0);
      rst_n = 1'b1;
      tick(10);
      check("idle_busy", busy, 0);

      // Write 05 <- A5, 06 <- 5A
      qb = wq_a.size();
      i2c_start;
      check("wr_busy", busy, 1);
      send_byte(8'h90, a0); send_byte(8'h05, a1);
      send_byte(8'hA5, a2); send_byte(8'h5A, a3);
      i2c_stop;
      check("wr_acks", {a0, a1, a2, a3}, 4'hF);
      check("wr_cnt",  wq_a.size() - qb, 2);
      if (wq_a.size() - qb == 2) begin
         check("wr_a0", wq_a[qb],   8'h05);
         check("wr_d0", wq_d[qb],   8'hA5);
         check("wr_a1", wq_a[qb+1], 8'h06);
         check("wr_d1", wq_d[qb+1], 8'h5A);
      end
      check("wr_final_addr", reg_addr, 8'h07);
      check("wr_stop_busy",  busy, 0);

      // Pointer write 0x10, repeated START, read 2 bytes
      qb = wq_a.size(); rb = n_rd;
      i2c_start;
      send_byte(8'h90, a0); send_byte(8'h10, a1);
      i2c_start;
      send_byte(8'h91, a2);
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      i2c_stop;
      check("rd_acks", {a0, a1, a2}, 3'h7);
      check("rd_b0",   d0, 8'h3C);
      check("rd_b1",   d1, 8'hC3);
      check("rd_stb",  n_rd - rb, 2);
      check("rd_nowr", wq_a.size() - qb, 0);
      check("rd_addr", reg_addr, 8'h12);

      // Wrong address: never drives, no strobes, busy until STOP
      qb = wq_a.size(); rb = n_rd; db = n_drv;
      i2c_start;
      send_byte(8'h92, a0); send_byte(8'h00, a1);
      check("bad_busy", busy, 1);
      i2c_stop;
      check("bad_ack",  a0, 0);
      check("bad_drv",  n_drv - db, 0);
      check("bad_wr",   wq_a.size() - qb, 0);
      check("bad_rd",   n_rd - rb, 0);
      check("bad_busy_stop", busy, 0);

      // Pointer wrap FF -> 00
      qb = wq_a.size();
      i2c_start;
      send_byte(8'h90, a0); send_byte(8'hFF, a1);
      send_byte(8'h11, a2); send_byte(8'h22, a3);
      i2c_stop;
      check("wrap_cnt", wq_a.size() - qb, 2);
      if (wq_a.size() - qb == 2) begin
         check("wrap_a0", wq_a[qb],   8'hFF);
         check("wrap_a1", wq_a[qb+1], 8'h00);
         check("wrap_d1", wq_d[qb+1], 8'h22);
      end
      check("wrap_addr", reg_addr, 8'h01);

      // Reset during the 4th data bit of a read of mem[0x20] = 00
      i2c_start;
      send_byte(8'h90, a0); send_byte(8'h20, a1);
      i2c_start;
      send_byte(8'h91, a2);
      check("mid_acks", {a0, a1, a2}, 3'h7);
      repeat (3) clk_bit(1'b1, s);
      tick(5);
      check("mid_pre_drv", drv, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_drv",  drv, 0);
      check("mid_rst_busy", busy, 0);
      tick(2);
      rst_n = 1'b1;
      db = n_drv;
      tick(3); scl = 1'b1;
      tick(6); scl = 1'b0;
      repeat (5) clk_bit(1'b1, s);
      i2c_stop;
      check("post_rst_drv", n_drv - db, 0);
      qb = wq_a.size();
      i2c_start;
      send_byte(8'h90, a0); send_byte(8'h30, a1); send_byte(8'h77, a2);
      i2c_stop;
      check("post_acks", {a0, a1, a2}, 3'h7);
      check("post_cnt",  wq_a.size() - qb, 1);
      if (wq_a.size() - qb == 1) begin
         check("post_a", wq_a[qb], 8'h30);
         check("post_d", wq_d[qb], 8'h77);
      end
      check("post_addr", reg_addr, 8'h31);

      // STOP in the middle of a data byte
      qb = wq_a.size();
      i2c_start;
      send_byte(8'h90, a0); send_byte(8'h40, a1);
      clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
      i2c_stop;
      check("stop_mid_wr",   wq_a.size() - qb, 0);
      check("stop_mid_busy", busy, 0);
      check("stop_mid_drv",  drv, 0);
      // back in IDLE: a byte without START gets no ACK
      db = n_drv;
      tick(5); scl = 1'b0;
      send_byte(8'h90, a0);
      tick(5); scl = 1'b1;
      tick(5);
      check("stop_idle_ack", a0, 0);
      check("stop_idle_drv", n_drv - db, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
